// File: rtl/addr_decoder_pkg.sv
// Shared types and constants for the address decoder: the default rule entry
// layout, the two matching modes and the index-width helper.
package addr_decoder_pkg;

   localparam bit ModeRange = 1'b0;
   localparam bit ModeNapot = 1'b1;

   // In Napot mode start_addr holds the base and end_addr holds the mask.
   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] start_addr;
      logic [31:0] end_addr;
   } addr_rule_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addr_decoder_comb.sv
// Combinational decode core: one comparator per rule, then a priority select
// in which the highest-numbered matching rule wins.
module addr_decoder_comb
   import addr_decoder_pkg::*;
#(
   parameter int unsigned NoIndices = 2,
   parameter int unsigned NoRules   = 1,
   parameter type         addr_t    = logic [31:0],
   parameter type         rule_t    = addr_rule_t,
   parameter bit          Napot     = ModeRange,
   parameter int unsigned IdxWidth  = idx_width(NoIndices)
) (
   input  addr_t                      addr_i,
   input  rule_t [NoRules-1:0]        addr_map_i,
   input  logic  [IdxWidth-1:0]       default_idx_i,
   input  logic                       en_default_idx_i,
   output logic  [IdxWidth-1:0]       idx_o,
   output logic                       dec_valid_o,
   output logic                       dec_error_o
);

   logic [NoRules-1:0] rule_match;

   for (genvar gi = 0; gi < NoRules; gi++) begin : g_rule
      addr_t start_addr;
      addr_t end_addr;
      assign start_addr = addr_t'(addr_map_i[gi].start_addr);
      assign end_addr   = addr_t'(addr_map_i[gi].end_addr);
      if (Napot) begin : g_napot
         assign rule_match[gi] = (addr_i & end_addr) == (start_addr & end_addr);
      end else begin : g_range
         // end_addr of zero means the range runs to the top of the address space.
         assign rule_match[gi] = (addr_i >= start_addr) &&
                                 ((addr_i < end_addr) || (end_addr == '0));
      end
   end

   always_comb begin
      idx_o       = en_default_idx_i ? default_idx_i : '0;
      dec_valid_o = 1'b0;
      for (int unsigned r = 0; r < NoRules; r++) begin
         if (rule_match[r]) begin
            idx_o       = addr_map_i[r].idx[IdxWidth-1:0];
            dec_valid_o = 1'b1;
         end
      end
      dec_error_o = !dec_valid_o && !en_default_idx_i;
   end

endmodule

// File: rtl/addr_decoder.sv
// Registered address decoder: the combinational core feeds a single output
// stage that captures a new result only on cycles where valid_i is high.
module addr_decoder
   import addr_decoder_pkg::*;
#(
   parameter int unsigned NoIndices = 2,
   parameter int unsigned NoRules   = 1,
   parameter type         addr_t    = logic [31:0],
   parameter type         rule_t    = addr_rule_t,
   parameter bit          Napot     = ModeRange,
   parameter int unsigned IdxWidth  = idx_width(NoIndices)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   input  addr_t                addr_i,
   input  rule_t [NoRules-1:0]  addr_map_i,
   input  logic  [IdxWidth-1:0] default_idx_i,
   input  logic                 en_default_idx_i,
   output logic                 valid_o,
   output logic  [IdxWidth-1:0] idx_o,
   output logic                 dec_valid_o,
   output logic                 dec_error_o
);

   logic [IdxWidth-1:0] idx_d, idx_q;
   logic                dec_valid_d, dec_valid_q;
   logic                dec_error_d, dec_error_q;
   logic                valid_q;

   addr_decoder_comb #(
      .NoIndices (NoIndices),
      .NoRules   (NoRules),
      .addr_t    (addr_t),
      .rule_t    (rule_t),
      .Napot     (Napot),
      .IdxWidth  (IdxWidth)
   ) u_comb (
      .addr_i           (addr_i),
      .addr_map_i       (addr_map_i),
      .default_idx_i    (default_idx_i),
      .en_default_idx_i (en_default_idx_i),
      .idx_o            (idx_d),
      .dec_valid_o      (dec_valid_d),
      .dec_error_o      (dec_error_d)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q     <= 1'b0;
         idx_q       <= '0;
         dec_valid_q <= 1'b0;
         dec_error_q <= 1'b0;
      end else begin
         valid_q <= valid_i;
         if (valid_i) begin
            idx_q       <= idx_d;
            dec_valid_q <= dec_valid_d;
            dec_error_q <= dec_error_d;
         end
      end
   end

   assign valid_o     = valid_q;
   assign idx_o       = idx_q;
   assign dec_valid_o = dec_valid_q;
   assign dec_error_o = dec_error_q;

`ifndef SYNTHESIS
   // Rule table sanity: indices must be in range, ranges must not be inverted.
   for (genvar gi = 0; gi < NoRules; gi++) begin : g_rule_chk
      always_ff @(posedge clk_i) begin
         if (rst_ni && valid_i) begin
            assert (addr_map_i[gi].idx < NoIndices);
            if (!Napot && (addr_map_i[gi].end_addr != '0)) begin
               assert (addr_map_i[gi].start_addr <= addr_map_i[gi].end_addr);
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_addr_decoder.sv
// Bench for addr_decoder: a range-mode and a Napot-mode instance share the
// stimulus and are compared against a rule-scanning reference model.
module tb_addr_decoder;
   import addr_decoder_pkg::*;

   localparam int unsigned NR  = 4;
   localparam int unsigned NNR = 2;
   localparam int unsigned NI  = 8;
   localparam int unsigned IW  = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          valid;
   logic [31:0]   addr;
   logic [IW-1:0] def_idx;
   logic          en_def;

   addr_rule_t rrules [NR];
   addr_rule_t nrules [NR];
   addr_rule_t [NR-1:0]  rmap;
   addr_rule_t [NNR-1:0] nmap;

   always_comb begin
      rmap = '0;
      nmap = '0;
      for (int i = 0; i < NR; i++) rmap[i] = rrules[i];
      for (int i = 0; i < NNR; i++) nmap[i] = nrules[i];
   end

   logic          r_valid, r_dv, r_de;
   logic [IW-1:0] r_idx;
   logic          n_valid, n_dv, n_de;
   logic [IW-1:0] n_idx;

   addr_decoder #(.NoIndices(NI), .NoRules(NR), .Napot(ModeRange)) u_rng (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .addr_i(addr),
      .addr_map_i(rmap), .default_idx_i(def_idx), .en_default_idx_i(en_def),
      .valid_o(r_valid), .idx_o(r_idx), .dec_valid_o(r_dv), .dec_error_o(r_de)
   );

   addr_decoder #(.NoIndices(NI), .NoRules(NNR), .Napot(ModeNapot)) u_np (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .addr_i(addr),
      .addr_map_i(nmap), .default_idx_i(def_idx), .en_default_idx_i(en_def),
      .valid_o(n_valid), .idx_o(n_idx), .dec_valid_o(n_dv), .dec_error_o(n_de)
   );

   int checks = 0;
   int errors = 0;

   // Expected (held) output state of each instance.
   bit          er_v, er_dv, er_de;
   int unsigned er_i;
   bit          en_v, en_dv, en_de;
   int unsigned en_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scan from the highest rule down; the first hit is the winner.
   function automatic void model(input bit napot, input int n, input addr_rule_t rules [NR],
                                 input logic [31:0] a, output bit hit, output int unsigned idx);
      bit ok;
      hit = 1'b0;
      idx = 0;
      for (int r = n - 1; r >= 0 && !hit; r--) begin
         if (napot)
            ok = ((a ^ rules[r].start_addr) & rules[r].end_addr) == 32'h0;
         else
            ok = (a >= rules[r].start_addr) &&
                 ((rules[r].end_addr == 32'h0) || (a < rules[r].end_addr));
         if (ok) begin
            hit = 1'b1;
            idx = rules[r].idx % NI;
         end
      end
   endfunction

   function automatic void update(input bit hit, input int unsigned idx, inout bit v,
                                  inout int unsigned oi, inout bit dv, inout bit de);
      if (!rst_n) begin
         v = 0; oi = 0; dv = 0; de = 0;
      end else begin
         v = valid;
         if (valid) begin
            oi = hit ? idx : (en_def ? int'(def_idx) : 0);
            dv = hit;
            de = !hit && !en_def;
         end
      end
   endfunction

   task automatic cycle(input string tag);
      bit hit;
      int unsigned idx;
      model(1'b0, NR, rrules, addr, hit, idx);
      update(hit, idx, er_v, er_i, er_dv, er_de);
      model(1'b1, NNR, nrules, addr, hit, idx);
      update(hit, idx, en_v, en_i, en_dv, en_de);
      @(posedge clk);
      #1;
      check({tag, ".r_valid"}, 32'(r_valid), 32'(er_v));
      check({tag, ".r_idx"},   32'(r_idx),   er_i);
      check({tag, ".r_dv"},    32'(r_dv),    32'(er_dv));
      check({tag, ".r_de"},    32'(r_de),    32'(er_de));
      check({tag, ".n_valid"}, 32'(n_valid), 32'(en_v));
      check({tag, ".n_idx"},   32'(n_idx),   en_i);
      check({tag, ".n_dv"},    32'(n_dv),    32'(en_dv));
      check({tag, ".n_de"},    32'(n_de),    32'(en_de));
   endtask

   function automatic addr_rule_t mk(input int unsigned i, input logic [31:0] s, input logic [31:0] e);
      addr_rule_t r;
      r.idx = i;
      r.start_addr = s;
      r.end_addr = e;
      return r;
   endfunction

   initial begin
      rst_n = 1'b0; valid = 1'b0; addr = '0; def_idx = '0; en_def = 1'b0;
      for (int i = 0; i < NR; i++) begin
         rrules[i] = mk(0, 32'hDEAD_0000, 32'hDEAD_0000);
         nrules[i] = mk(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
      er_v = 1; er_i = 7; er_dv = 1; er_de = 1;
      en_v = 1; en_i = 7; en_dv = 1; en_de = 1;
      valid = 1'b1; addr = 32'h14;
      cycle("reset0");
      cycle("reset1");
      rst_n = 1'b1;

      rrules[0] = mk(1, 32'h00, 32'h10);
      rrules[1] = mk(2, 32'h10, 32'h20);
      nrules[0] = mk(3, 32'h40, 32'hF0);
      addr = 32'h14; cycle("in_range");
      addr = 32'h30; en_def = 1; def_idx = 3; cycle("default_on");
      en_def = 0; cycle("default_off");
      addr = 32'h4F; cycle("napot_hit");
      addr = 32'h50; cycle("napot_miss");

      rrules[0] = mk(1, 32'h0, 32'h100);
      rrules[1] = mk(2, 32'h80, 32'h90);
      addr = 32'h85; cycle("overlap");
      addr = 32'h90; cycle("upper_excl");
      rrules[2] = mk(1, 32'hFFFF_0000, 32'h0);
      addr = 32'hFFFF_FFFF; cycle("unbounded");
      addr = 32'hDEAD_0000; cycle("empty_range");

      valid = 0; addr = 32'h85; cycle("hold0");
      addr = 32'h14; cycle("hold1");
      valid = 1; addr = 32'h4F; rst_n = 0; cycle("mid_reset");
      rst_n = 1; valid = 0; cycle("post_reset");
      valid = 1; cycle("first_valid");

      for (int n = 0; n < 400; n++) begin
         if (n % 16 == 0) begin
            for (int r = 0; r < NR; r++) begin
               logic [31:0] s, e;
               s = $urandom_range(0, 255);
               case ($urandom_range(0, 5))
                  0:       e = 32'h0;
                  1:       e = s;
                  default: e = s + $urandom_range(1, 64);
               endcase
               if ($urandom_range(0, 7) == 0) begin
                  s = 32'hFFFF_FF00 | s;
                  e = 32'h0;
               end
               rrules[r] = mk($urandom_range(0, NI - 1), s, e);
            end
            for (int r = 0; r < NNR; r++) begin
               logic [31:0] m;
               m = 32'hFFFF_FFFF << $urandom_range(0, 8);
               nrules[r] = mk($urandom_range(0, NI - 1), $urandom_range(0, 511) & m, m);
            end
         end
         case ($urandom_range(0, 7))
            0:       addr = 32'hFFFF_FF00 | $urandom_range(0, 255);
            1:       addr = $urandom;
            default: addr = $urandom_range(0, 511);
         endcase
         valid   = ($urandom_range(0, 4) != 0);
         rst_n   = ($urandom_range(0, 19) != 0);
         en_def  = $urandom_range(0, 1) == 1;
         def_idx = IW'($urandom_range(0, NI - 1));
         cycle("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
